disp_pll_supervisor: RTL and testbench
======================================

// Module: disp_pll_supervisor
// PURPOSE
//  Supervises the display PLL from the 25 MHz reference clock domain.
//  - Drives the PLL reset and qualifies its lock output.
//  - Generates the synchronous reset for display logic.
//  - Checks output frequency by counting a PLL-domain toggle bit over a fixed window.
//  - Counts lock-loss events.
// PARAMETERS
//  SYNC_STAGES    2     synchroniser depth on async inputs (>=2)
//  PLL_RST_CYC    16    cycles pll_reset is held high per attempt
//  LOCK_TIMEOUT   65535 cycles to wait for lock before retrying PLL reset
//  LOCK_STABLE    1024  cycles lock must stay high continuously before release
//  RST_HOLD       64    extra cycles disp_reset is held after stable lock
//  MEAS_WIN       4096  measurement window length, in clk cycles
//  EXP_EDGES      1638  expected toggle edges per window
//  TOL            8     allowed +/- deviation from EXP_EDGES
// PORTS
//  clk            in   1   25 MHz reference clock
//  reset          in   1   synchronous, active-high
//  pll_lock       in   1   PLL lock, async; synchronised internally
//  pll_tog        in   1   bit toggled in PLL domain, async; synchronised internally
//  clear_stats    in   1   1-cycle pulse; zeroes lock_loss_cnt and retry_cnt
//  pll_reset      out  1   to PLL RESET
//  disp_reset     out  1   synchronous reset for display domain logic
//  locked_ok      out  1   high only in state RUN
//  freq_count     out  16  edge count of last completed window
//  freq_valid     out  1   1-cycle pulse when freq_count updates
//  freq_err       out  1   sticky: last window outside EXP_EDGES +/- TOL
//  lock_loss_cnt  out  8   saturating count of lock drops while in RUN
//  retry_cnt      out  8   saturating count of LOCK_TIMEOUT expiries
// BEHAVIOUR
//  Reset values: pll_reset=1, disp_reset=1, locked_ok=0, freq_count=0,
//   freq_valid=0, freq_err=0, lock_loss_cnt=0, retry_cnt=0, state=PRST, counters=0.
//  Synchroniser: lock_s, tog_s are SYNC_STAGES flops deep. Edge = tog_s XOR its previous value.
//  FSM; a single down/up counter `cnt` is cleared on every state entry.
//  - PRST: pll_reset=1.
//    -> WAIT after PLL_RST_CYC cycles.
//  - WAIT: pll_reset=0.
//    -> STAB if lock_s=1.
//    -> PRST if cnt reaches LOCK_TIMEOUT; retry_cnt +1, saturating at 255.
//  - STAB: -> WAIT if lock_s=0 (no counter increment).
//    -> HOLD once lock_s has been 1 for LOCK_STABLE consecutive cycles.
//  - HOLD: -> WAIT if lock_s=0.
//    -> RUN after RST_HOLD cycles.
//  - RUN: locked_ok=1, disp_reset=0.
//    -> WAIT if lock_s=0; lock_loss_cnt +1, saturating at 255.
//  disp_reset=1 in every state except RUN. It is registered:
//   - deasserts the cycle after RUN entry;
//   - reasserts the cycle after the lock_s=0 sample.
//  Measurement runs only in RUN. Window counter and edge counter restart at RUN entry.
//  - Edge counter is 16 bits and saturates at 0xFFFF (no wrap).
//  - On the cycle that completes MEAS_WIN cycles: freq_count <= edges, freq_valid=1.
//    If an edge occurs on this cycle, it counts in the new window, not the closing one.
//  - In the same cycle, freq_err <= (edges < EXP_EDGES-TOL) || (edges > EXP_EDGES+TOL).
//  - Leaving RUN mid-window discards the partial window; freq_count/freq_err are held.
//  clear_stats: zeroes both stat counters.
//   - If it coincides with an increment, the clear wins (result 0).
//   - freq_err is cleared only by reset.
//  reset mid-operation: all state returns to reset values the next cycle; PLL is reset again.
// TESTING
//  1 Small params (PLL_RST_CYC=4, LOCK_STABLE=8, RST_HOLD=4). After reset, pll_lock=1
//    -> pll_reset low after 4 cycles; disp_reset low 2+8+4 cycles later (+/- 1 sync).
//  2 LOCK_TIMEOUT=20, pll_lock held 0
//    -> pll_reset pulses every 4+20 cycles; retry_cnt=3 after 3 timeouts.
//  3 Lock glitch low 1 cycle during STAB at count 5
//    -> stable count restarts; release delayed by the elapsed count.
//  4 In RUN, drop lock 300 times
//    -> lock_loss_cnt=255 (saturated); disp_reset high the cycle after each drop.
//    -> clear_stats together with a drop gives 0.
//  5 MEAS_WIN=100, EXP=40, TOL=2, toggle every 2.5 cycles (40/window)
//    -> freq_count=40, freq_err=0.
//    -> at 46/window: freq_err=1, and it stays 1 after returning to 40.
//  6 Assert reset mid-HOLD
//    -> pll_reset=1 and disp_reset=1 next cycle; sequence restarts from PRST.

Source files
------------

// File: rtl/disp_pll_supervisor.sv
// Display PLL supervisor, running in the 25 MHz reference clock domain.
// Sequences the PLL reset, qualifies lock before releasing the display
// reset, measures the PLL output frequency through a toggle bit, and keeps
// saturating counts of lock losses and lock timeouts.
//
// Input handshake note: clear_stats is a plain one-cycle strobe with no
// valid/ready pairing; it is acted on in the cycle it is high.
module disp_pll_supervisor #(
  parameter int SYNC_STAGES  = 2,
  parameter int PLL_RST_CYC  = 16,
  parameter int LOCK_TIMEOUT = 65535,
  parameter int LOCK_STABLE  = 1024,
  parameter int RST_HOLD     = 64,
  parameter int MEAS_WIN     = 4096,
  parameter int EXP_EDGES    = 1638,
  parameter int TOL          = 8
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        pll_lock,
  input  logic        pll_tog,
  input  logic        clear_stats,
  output logic        pll_reset,
  output logic        disp_reset,
  output logic        locked_ok,
  output logic [15:0] freq_count,
  output logic        freq_valid,
  output logic        freq_err,
  output logic [7:0]  lock_loss_cnt,
  output logic [7:0]  retry_cnt
);

  typedef enum logic [2:0] {
    S_PRST = 3'd0,
    S_WAIT = 3'd1,
    S_STAB = 3'd2,
    S_HOLD = 3'd3,
    S_RUN  = 3'd4
  } state_t;

  localparam logic [15:0] EDGE_LO = 16'(EXP_EDGES - TOL);
  localparam logic [15:0] EDGE_HI = 16'(EXP_EDGES + TOL);

  state_t                 state_q, state_d;
  logic [31:0]            cnt_q, cnt_d;
  logic [SYNC_STAGES-1:0] lock_sync_q, lock_sync_d;
  logic [SYNC_STAGES-1:0] tog_sync_q, tog_sync_d;
  logic                   tog_prev_q, tog_prev_d;
  logic [15:0]            edges_q, edges_d;
  logic [15:0]            freq_count_q, freq_count_d;
  logic                   freq_valid_q, freq_valid_d;
  logic                   freq_err_q, freq_err_d;
  logic [7:0]             lock_loss_q, lock_loss_d;
  logic [7:0]             retry_q, retry_d;
  logic                   disp_reset_q, disp_reset_d;
  logic                   lock_s, tog_s, edge_det;
  logic                   loss_inc, retry_inc;
  logic [15:0]            edges_sat;

  assign lock_s    = lock_sync_q[SYNC_STAGES-1];
  assign tog_s     = tog_sync_q[SYNC_STAGES-1];
  assign edge_det  = tog_s ^ tog_prev_q;
  assign edges_sat = (edges_q == 16'hFFFF) ? edges_q : edges_q + {15'd0, edge_det};

  // Next-state logic: FSM, shared state counter, frequency window and stats.
  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q + 32'd1;
    lock_sync_d  = {lock_sync_q[SYNC_STAGES-2:0], pll_lock};
    tog_sync_d   = {tog_sync_q[SYNC_STAGES-2:0], pll_tog};
    tog_prev_d   = tog_s;
    edges_d      = edges_q;
    freq_count_d = freq_count_q;
    freq_valid_d = 1'b0;
    freq_err_d   = freq_err_q;
    loss_inc     = 1'b0;
    retry_inc    = 1'b0;

    case (state_q)
      S_PRST: begin
        if (cnt_q == 32'(PLL_RST_CYC - 1)) state_d = S_WAIT;
      end
      S_WAIT: begin
        if (lock_s) begin
          state_d = S_STAB;
        end else if (cnt_q == 32'(LOCK_TIMEOUT - 1)) begin
          state_d   = S_PRST;
          retry_inc = 1'b1;
        end
      end
      S_STAB: begin
        if (!lock_s) state_d = S_WAIT;
        else if (cnt_q == 32'(LOCK_STABLE - 1)) state_d = S_HOLD;
      end
      S_HOLD: begin
        if (!lock_s) state_d = S_WAIT;
        else if (cnt_q == 32'(RST_HOLD - 1)) state_d = S_RUN;
      end
      S_RUN: begin
        if (!lock_s) begin
          state_d  = S_WAIT;
          loss_inc = 1'b1;
        end else if (cnt_q == 32'(MEAS_WIN - 1)) begin
          // Window closes: an edge seen now opens the next window.
          cnt_d        = 32'd0;
          freq_count_d = edges_q;
          freq_valid_d = 1'b1;
          freq_err_d   = freq_err_q | (edges_q < EDGE_LO) | (edges_q > EDGE_HI);
          edges_d      = {15'd0, edge_det};
        end else begin
          edges_d = edges_sat;
        end
      end
      default: state_d = S_PRST;
    endcase

    // Every state entry restarts the counter; RUN entry also opens a fresh window.
    if (state_d != state_q) begin
      cnt_d   = 32'd0;
      edges_d = (state_d == S_RUN) ? {15'd0, edge_det} : 16'd0;
    end

    lock_loss_d = lock_loss_q;
    if (clear_stats) lock_loss_d = 8'd0;
    else if (loss_inc && lock_loss_q != 8'hFF) lock_loss_d = lock_loss_q + 8'd1;

    retry_d = retry_q;
    if (clear_stats) retry_d = 8'd0;
    else if (retry_inc && retry_q != 8'hFF) retry_d = retry_q + 8'd1;

    // Registered so release lags RUN entry by one cycle and reassertion
    // follows the first low lock sample.
    disp_reset_d = !((state_q == S_RUN) && lock_s);
  end

  // State registers with synchronous active-high reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= S_PRST;
      cnt_q        <= '0;
      lock_sync_q  <= '0;
      tog_sync_q   <= '0;
      tog_prev_q   <= 1'b0;
      edges_q      <= '0;
      freq_count_q <= '0;
      freq_valid_q <= 1'b0;
      freq_err_q   <= 1'b0;
      lock_loss_q  <= '0;
      retry_q      <= '0;
      disp_reset_q <= 1'b1;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      lock_sync_q  <= lock_sync_d;
      tog_sync_q   <= tog_sync_d;
      tog_prev_q   <= tog_prev_d;
      edges_q      <= edges_d;
      freq_count_q <= freq_count_d;
      freq_valid_q <= freq_valid_d;
      freq_err_q   <= freq_err_d;
      lock_loss_q  <= lock_loss_d;
      retry_q      <= retry_d;
      disp_reset_q <= disp_reset_d;
    end
  end

  assign pll_reset     = (state_q == S_PRST);
  assign locked_ok     = (state_q == S_RUN);
  assign disp_reset    = disp_reset_q;
  assign freq_count    = freq_count_q;
  assign freq_valid    = freq_valid_q;
  assign freq_err      = freq_err_q;
  assign lock_loss_cnt = lock_loss_q;
  assign retry_cnt     = retry_q;

endmodule

// File: tb/tb_disp_pll_supervisor.sv
// Bench for disp_pll_supervisor with shortened timing parameters.
module tb_disp_pll_supervisor;

  localparam int PLL_RST_CYC  = 4;
  localparam int LOCK_TIMEOUT = 20;
  localparam int LOCK_STABLE  = 8;
  localparam int RST_HOLD     = 4;
  localparam int MEAS_WIN     = 100;
  localparam int EXP_EDGES    = 40;
  localparam int TOL          = 2;

  localparam int SEL_PLL  = 0;
  localparam int SEL_DISP = 1;
  localparam int SEL_LOCK = 2;
  localparam int SEL_FV   = 3;

  logic        clk, reset, pll_lock, pll_tog, clear_stats;
  logic        pll_reset, disp_reset, locked_ok, freq_valid, freq_err;
  logic [15:0] freq_count;
  logic [7:0]  lock_loss_cnt, retry_cnt;

  int checks = 0;
  int fails  = 0;
  int tog_rate = 40;
  int tog_c = 0;

  typedef struct {
    int          rate;
    logic [15:0] exp_count;
    logic        exp_err;
  } freq_vec_t;

  freq_vec_t vecs[6];

  disp_pll_supervisor #(
    .SYNC_STAGES(2), .PLL_RST_CYC(PLL_RST_CYC), .LOCK_TIMEOUT(LOCK_TIMEOUT),
    .LOCK_STABLE(LOCK_STABLE), .RST_HOLD(RST_HOLD), .MEAS_WIN(MEAS_WIN),
    .EXP_EDGES(EXP_EDGES), .TOL(TOL)
  ) dut (
    .clk(clk), .reset(reset), .pll_lock(pll_lock), .pll_tog(pll_tog),
    .clear_stats(clear_stats), .pll_reset(pll_reset), .disp_reset(disp_reset),
    .locked_ok(locked_ok), .freq_count(freq_count), .freq_valid(freq_valid),
    .freq_err(freq_err), .lock_loss_cnt(lock_loss_cnt), .retry_cnt(retry_cnt)
  );

  // Clock and watchdog
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #3_000_000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1, "watchdog");
  end

  // PLL toggle driver: exactly tog_rate toggles in any 100 consecutive cycles.
  initial begin
    pll_tog = 1'b0;
    forever begin
      @(negedge clk);
      if ((((tog_c + 1) * tog_rate) / 100) != ((tog_c * tog_rate) / 100)) pll_tog = ~pll_tog;
      tog_c++;
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  function automatic logic pick(input int sel);
    case (sel)
      SEL_PLL:  return pll_reset;
      SEL_DISP: return disp_reset;
      SEL_LOCK: return locked_ok;
      SEL_FV:   return freq_valid;
      default:  return 1'b0;
    endcase
  endfunction

  // Returns the number of falling clock edges until the selected output
  // reads val, or -1 if it never does within limit.
  task automatic wait_for(input int sel, input logic val, input int limit, output int n);
    n = -1;
    for (int i = 1; i <= limit; i++) begin
      @(negedge clk);
      if (pick(sel) === val) begin
        n = i;
        break;
      end
    end
  endtask

  // Holds reset for three cycles, checks reset values, then releases it.
  task automatic do_reset();
    reset = 1'b1;
    clear_stats = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_pll_reset", pll_reset, 1);
    check("rst_disp_reset", disp_reset, 1);
    check("rst_locked_ok", locked_ok, 0);
    check("rst_freq_count", freq_count, 0);
    check("rst_freq_valid", freq_valid, 0);
    check("rst_freq_err", freq_err, 0);
    check("rst_lock_loss_cnt", lock_loss_cnt, 0);
    check("rst_retry_cnt", retry_cnt, 0);
    reset = 1'b0;
  endtask

  initial begin
    int n;
    vecs[0] = '{rate: 40, exp_count: 16'd40, exp_err: 1'b0};
    vecs[1] = '{rate: 42, exp_count: 16'd42, exp_err: 1'b0};
    vecs[2] = '{rate: 38, exp_count: 16'd38, exp_err: 1'b0};
    vecs[3] = '{rate: 43, exp_count: 16'd43, exp_err: 1'b1};
    vecs[4] = '{rate: 46, exp_count: 16'd46, exp_err: 1'b1};
    vecs[5] = '{rate: 40, exp_count: 16'd40, exp_err: 1'b1};

    reset = 1'b1;
    pll_lock = 1'b1;
    clear_stats = 1'b0;

    // Lock present from the start: release timing.
    do_reset();
    wait_for(SEL_PLL, 1'b0, 50, n);
    check("t1_pll_reset_low_after", n, 4);
    wait_for(SEL_DISP, 1'b0, 60, n);
    check("t1_disp_reset_low_after", n, 14);
    check("t1_locked_ok", locked_ok, 1);

    // One-cycle lock glitch while stabilising at count 5.
    do_reset();
    repeat (8) @(negedge clk);
    pll_lock = 1'b0;
    @(negedge clk);
    pll_lock = 1'b1;
    wait_for(SEL_DISP, 1'b0, 80, n);
    check("t3_disp_release_after_glitch", n, 16);
    check("t3_no_lock_loss", lock_loss_cnt, 0);
    check("t3_no_retry", retry_cnt, 0);

    // Reset asserted while holding.
    do_reset();
    repeat (14) @(negedge clk);
    check("t6_hold_pll_reset", pll_reset, 0);
    check("t6_hold_disp_reset", disp_reset, 1);
    reset = 1'b1;
    @(negedge clk);
    check("t6_pll_reset_after_rst", pll_reset, 1);
    check("t6_disp_reset_after_rst", disp_reset, 1);
    check("t6_locked_ok_after_rst", locked_ok, 0);
    reset = 1'b0;
    wait_for(SEL_PLL, 1'b0, 50, n);
    check("t6_restart_pll_low_after", n, 4);
    wait_for(SEL_DISP, 1'b0, 60, n);
    check("t6_restart_disp_low_after", n, 14);

    // No lock: PLL reset retried after each timeout.
    pll_lock = 1'b0;
    do_reset();
    for (int r = 1; r <= 3; r++) begin
      wait_for(SEL_PLL, 1'b0, 60, n);
      check("t2_pll_reset_high_len", n, (r == 1) ? 4 : 4);
      wait_for(SEL_PLL, 1'b1, 60, n);
      check("t2_wait_len", n, 20);
      check("t2_retry_cnt", retry_cnt, r);
    end

    // Bring up lock and reach RUN for the frequency checks.
    pll_lock = 1'b1;
    wait_for(SEL_LOCK, 1'b1, 100, n);
    check("run_reached", (n > 0) ? 1 : 0, 1);

    // Frequency windows.
    for (int v = 0; v < 6; v++) begin
      tog_rate = vecs[v].rate;
      wait_for(SEL_FV, 1'b1, 250, n);
      wait_for(SEL_FV, 1'b1, 250, n);
      wait_for(SEL_FV, 1'b1, 250, n);
      check("t5_window_period", n, MEAS_WIN);
      check("t5_freq_count", freq_count, vecs[v].exp_count);
      check("t5_freq_err", freq_err, vecs[v].exp_err);
    end

    // Repeated lock drops in RUN.
    for (int i = 0; i < 300; i++) begin
      wait_for(SEL_LOCK, 1'b1, 100, n);
      check("t4_run_reentry", (n > 0) ? 1 : 0, 1);
      pll_lock = 1'b0;
      @(negedge clk);
      pll_lock = 1'b1;
      @(negedge clk);
      check("t4_disp_low_before_sample", disp_reset, 0);
      @(negedge clk);
      check("t4_disp_high_after_drop", disp_reset, 1);
      check("t4_locked_ok_low", locked_ok, 0);
      check("t4_lock_loss_cnt", lock_loss_cnt, (i + 1 > 255) ? 255 : i + 1);
    end
    check("t4_retry_before_clear", retry_cnt, 3);

    // Clear coinciding with a drop.
    wait_for(SEL_LOCK, 1'b1, 100, n);
    pll_lock = 1'b0;
    @(negedge clk);
    pll_lock = 1'b1;
    @(negedge clk);
    clear_stats = 1'b1;
    @(negedge clk);
    clear_stats = 1'b0;
    check("t4_clear_wins_loss", lock_loss_cnt, 0);
    check("t4_clear_retry", retry_cnt, 0);
    check("t4_freq_err_survives_clear", freq_err, 1);

    // Counting resumes after clear.
    wait_for(SEL_LOCK, 1'b1, 100, n);
    pll_lock = 1'b0;
    @(negedge clk);
    pll_lock = 1'b1;
    repeat (2) @(negedge clk);
    check("t4_count_after_clear", lock_loss_cnt, 1);

    // Final reset clears sticky error and stats.
    do_reset();

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
